// File: rtl/sccb_arbiter.sv
// Purpose : two-port SCCB write arbiter; port 0 (ROM config) has priority, port 1 (runtime tweaks) is starvation-protected.
// Latency : request sampled in IDLE at edge N -> sccb_start and ack high during cycle N+1.
// Backpressure: no grant while sccb_ready=0; requesters hold req/addr/data until their ack pulse.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req0/addr0/data0, ack0   port 0 command in, 1-cycle accept pulse out
//   req1/addr1/data1, ack1   port 1 command in, 1-cycle accept pulse out
//   sccb_ready               SCCB master idle
//   sccb_start/addr/data     start strobe and latched command to the SCCB master
//   grant                    one-hot current owner, 00 when idle
//   busy                     high whenever not IDLE
//   timeout_err, clear_err   sticky watchdog flag and its clear
module sccb_arbiter #(
    parameter int CLK_FREQ       = 25000000,
    parameter int GAP_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 100,
    parameter int MAX_CONSEC     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] addr0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] addr1,
    input  logic [7:0] data1,
    output logic       ack1,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    input  logic       clear_err
);

    localparam int CW = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_consec;
    logic [31:0]     r_wdog;
    logic [31:0]     r_gap_cnt;

    logic w_any_req;
    logic w_consec_full;
    logic w_pick1;

    assign w_any_req     = req0 | req1;
    assign w_consec_full = (r_consec == CW'(MAX_CONSEC));
    // Port 1 wins when alone, or when port 0 has used up its consecutive-grant allowance.
    assign w_pick1       = req1 & (~req0 | w_consec_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_consec    <= '0;
            r_wdog      <= '0;
            r_gap_cnt   <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            sccb_start  <= 1'b0;
            sccb_addr   <= '0;
            sccb_data   <= '0;
            grant       <= 2'b00;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sccb_start <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;

            // A watchdog set later in this block overrides the clear.
            if (clear_err)
                timeout_err <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (sccb_ready && w_any_req) begin
                        r_state    <= ISSUE;
                        busy       <= 1'b1;
                        sccb_start <= 1'b1;
                        if (w_pick1) begin
                            grant     <= 2'b10;
                            ack1      <= 1'b1;
                            sccb_addr <= addr1;
                            sccb_data <= data1;
                            r_consec  <= '0;
                        end else begin
                            grant     <= 2'b01;
                            ack0      <= 1'b1;
                            sccb_addr <= addr0;
                            sccb_data <= data0;
                            // Only grants that make port 1 wait count toward the allowance.
                            if (req1) begin
                                if (!w_consec_full)
                                    r_consec <= r_consec + 1'b1;
                            end else begin
                                r_consec <= '0;
                            end
                        end
                    end
                end

                ISSUE: begin
                    r_state <= WAIT_BUSY;
                    r_wdog  <= '0;
                end

                WAIT_BUSY, WAIT_DONE: begin
                    // One counter spans both wait states so the budget covers the whole transfer.
                    if (r_wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        r_state     <= GAP;
                        r_gap_cnt   <= '0;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                        if (r_state == WAIT_BUSY && !sccb_ready) begin
                            r_state <= WAIT_DONE;
                        end else if (r_state == WAIT_DONE && sccb_ready) begin
                            r_state   <= GAP;
                            r_gap_cnt <= '0;
                        end
                    end
                end

                GAP: begin
                    // Always at least one cycle here, even with a zero gap.
                    if (r_gap_cnt + 32'd1 >= 32'(GAP_CYCLES)) begin
                        r_state <= IDLE;
                        grant   <= 2'b00;
                        busy    <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
